// File: rtl/approx_booth_mac_pipe_if.sv
// Operand-beat and burst-result handshake bundle for the approximate Booth MAC.
// The master drives beats and out_ready. The slave (the MAC) drives in_ready and results.
interface approx_booth_mac_pipe_if #(
    parameter int W     = 12,
    parameter int ACC_W = 24,
    parameter int LVL_W = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     in_a;
    logic signed [W-1:0]     in_b;
    logic [LVL_W-1:0]        in_lvl;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_lvl, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_lvl, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/approx_booth_mac_pipe.sv
// Pipelined radix-4 Booth MAC with per-beat column truncation, rounding and a saturating burst sum.
// Stages: input capture, Booth partial products, reduction plus rounding, then accumulate/saturate.
module approx_booth_pp #(
    parameter int W  = 12,
    parameter int PW = 25,
    parameter int J  = 0,
    parameter int KW = 3
) (
    input  logic signed [W-1:0]  a,
    input  logic [2:0]           trip,
    input  logic [KW-1:0]        k,
    output logic signed [PW-1:0] pp
);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] m;

    always_comb begin
        ax = PW'(a);
        case (trip)
            3'b001, 3'b010: m = ax;
            3'b011:         m = ax <<< 1;
            3'b100:         m = -(ax <<< 1);
            3'b101, 3'b110: m = -ax;
            default:        m = '0;
        endcase
        // Clearing the low k columns of a two's-complement value is a floor to 2^k.
        pp = (m <<< (2 * J)) & ({PW{1'b1}} << k);
    end
endmodule

module approx_booth_mac_pipe #(
    parameter int W     = 12,
    parameter int ACC_W = 24,
    parameter int LVL_W = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    approx_booth_mac_pipe_if.slave bus
);
    localparam int NPP    = W / 2;
    localparam int PW     = 2 * W + 1;
    localparam int KW     = LVL_W + 1;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [LVL_W-1:0] lvl;
    } beat_t;

    logic                    adv;
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0]         last_pipe;
    beat_t                   s0;
    logic [W:0]              bext;
    logic [KW-1:0]           s0_k;
    logic [KW-1:0]           s1_k;
    logic [NPP-1:0][PW-1:0]  pp_c;
    logic [NPP-1:0][PW-1:0]  s1_pp;
    logic signed [PW-1:0]    sum_c;
    logic signed [PW-1:0]    s2_prod;
    logic signed [ACC_W:0]   base;
    logic signed [ACC_W:0]   accx;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_c;
    logic                    ovf;
    logic                    ovf_c;
    logic                    first;
    logic                    hi;
    logic                    lo;

    // Global stall: nothing moves while a result waits on downstream.
    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;

    assign bext = {s0.b, 1'b0};
    assign s0_k = {s0.lvl, 1'b0};

    for (genvar j = 0; j < NPP; j++) begin : g_pp
        approx_booth_pp #(.W(W), .PW(PW), .J(j), .KW(KW)) u_pp (
            .a    (s0.a),
            .trip (bext[2*j+2 : 2*j]),
            .k    (s0_k),
            .pp   (pp_c[j])
        );
    end

    always_comb begin
        sum_c = (s1_k == '0) ? '0 : (PW'(1) << (s1_k - 1'b1));
        for (int j = 0; j < NPP; j++) begin
            sum_c = sum_c + s1_pp[j];
        end
    end

    // Both operands fit ACC_W bits, so one extra bit exposes any overflow.
    always_comb begin
        base  = first ? '0 : (ACC_W+1)'(acc);
        accx  = base + (ACC_W+1)'(s2_prod);
        hi    = !accx[ACC_W] && accx[ACC_W-1];
        lo    = accx[ACC_W] && !accx[ACC_W-1];
        acc_c = hi ? {1'b0, {(ACC_W-1){1'b1}}} :
                lo ? {1'b1, {(ACC_W-1){1'b0}}} : accx[ACC_W-1:0];
        ovf_c = (!first && ovf) || hi || lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            s0        <= '0;
            s1_pp     <= '0;
            s1_k      <= '0;
            s2_prod   <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], bus.in_valid};
            last_pipe <= {last_pipe[STAGES-1:0], bus.in_valid && bus.in_last};
            if (bus.in_valid) s0 <= {bus.in_a, bus.in_b, bus.in_lvl};
            if (vld_pipe[0]) begin
                s1_pp <= pp_c;
                s1_k  <= s0_k;
            end
            if (vld_pipe[1]) s2_prod <= sum_c;
        end
    end

    // first marks that the next beat reaching the accumulator opens a new burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            ovf           <= 1'b0;
            first         <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= vld_pipe[STAGES] && last_pipe[STAGES];
            if (vld_pipe[STAGES]) begin
                acc   <= acc_c;
                ovf   <= ovf_c;
                first <= last_pipe[STAGES];
                if (last_pipe[STAGES]) begin
                    bus.out_sum <= acc_c;
                    bus.out_ovf <= ovf_c;
                end
            end
        end
    end
endmodule

// File: doc/approx_booth_mac_pipe.md
Name: approx_booth_mac_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiply-accumulate with a run-time approximation level.
- Each beat carries its own level. At level L, every shifted partial product has its low 2*L columns truncated, and a rounding constant is added to the product.
- Products are summed over a burst delimited by in_last. The saturated burst sum is emitted on a valid/ready output.
- Sits between operand streams and the accumulation/activation logic of the datapath.

Parameters:
- W, 12: operand width in bits, signed; must be even, >= 4.
- ACC_W, 24: accumulator/result width in bits, signed; must be >= 2*W.
- LVL_W, 2: width of the level field. Max level is 2^LVL_W-1 and must satisfy 2*max <= W.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  W  multiplicand, signed.
- in_b  in  W  multiplier (Booth-recoded), signed.
- in_lvl  in  LVL_W  approximation level for this beat; 0 = exact.
- in_last  in  1  final beat of the burst.
- out_valid  out  1  burst result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  saturated burst sum, signed.
- out_ovf  out  1  saturation occurred at any point in this burst.

Behaviour:
- Reset (async assert, sync release): all pipeline valids, accumulator, out_valid, out_sum and out_ovf go to 0. Reset mid-burst discards the partial sum and in-flight beats.
- Handshake:
  - A beat transfers when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - adv = !(out_valid && !out_ready); in_ready = adv.
  - The whole pipeline advances only when adv=1, i.e. it stalls globally under backpressure.
  - out_sum/out_ovf are held stable while out_valid && !out_ready.
- Pipeline: S1 Booth encode + partial-product generation, S2 partial-product reduction + compensation, S3 accumulate/saturate. in_lvl and in_last travel with their beat.
- Latency: a last beat accepted at edge t (no stall) gives out_valid=1 after edge t+3. Non-last beats produce no output.
- Throughput: one beat per cycle. Back-to-back bursts need no bubble; the first beat of burst N+1 accumulates from 0 in the cycle after burst N's last beat.
- Arithmetic, normative model:
  - Booth digits: d_j = -2*b[2j+1] + b[2j] + b[2j-1], for j = 0..W/2-1, with b[-1]=0.
  - Partial products: P_j = (d_j*a) << 2j, exact signed integer.
  - Truncation: K = 2*L. trunc_K(x) = x with bits [K-1:0] cleared in two's complement, i.e. floor(x/2^K)*2^K.
  - Product: prod = sum_j trunc_K(P_j) + (K>0 ? 2^(K-1) : 0).
  - At L=0, prod = a*b exactly. prod fits in 2*W+1 bits and is sign-extended to ACC_W+1 for accumulation.
- Accumulate/saturate:
  - acc_next = (first beat of burst ? 0 : acc) + prod, computed in ACC_W+1 bits.
  - If the result exceeds 2^(ACC_W-1)-1, clamp to that value; if it is below -2^(ACC_W-1), clamp to that value. Set the burst sticky ovf.
  - Saturation is sticky per step: later beats add to the clamped value.
  - ovf clears at burst start.
- Boundary conditions:
  - A single-beat burst (in_last on the first beat) is legal.
  - in_lvl above the supported max is treated as the max.
  - in_valid=0 inserts bubbles with no state change except a pipeline shift.
  - out_ready may be held high permanently.
  - A stall arriving in the same cycle as out_valid rising holds the result until accepted.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_sum=0, out_ovf=0. Release, then one beat a=3, b=5, L=0, last -> out_sum=15, out_ovf=0, valid 3 cycles after accept.
- Extremes: single beat a=-2048, b=-2048, L=0 -> out_sum=4194304. Then a=-2048, b=2047, L=0 -> -4192256.
- Approximation: a=1, b=1, L=1 -> 2. a=-1, b=1, L=1 -> -2. a=100, b=100, L=0 -> 10000.
- Saturation: three beats a=-2048, b=-2048, L=0, last on the third -> out_sum=8388607, out_ovf=1. The next burst a=1, b=1, L=0 -> 1, ovf=0.
- Backpressure: 4-beat bursts back-to-back with out_ready=0 for 5 cycles when the first result appears -> in_ready=0 during the stall, out_sum held, no beats lost, both sums correct.
- Random regression: random a, b, L, burst lengths 1..16, random out_ready, mid-run reset -> every result matches the normative model bit-exactly; nothing is emitted for a burst cut by reset.
